// File: rtl/lcd_bus_decoder.sv
// Passive HD44780-style LCD bus receiver keeping a 32-character display shadow.
// Define LCD_DEC_SYNC_EN to put a 2-flop synchronizer on every bus input.
//   state    | meaning
//   ST_IDLE  | decode bus writes into cursor/shadow/command outputs
//   ST_CLEAR | fill shadow with spaces, one entry per cycle, bus dropped
module lcd_bus_decoder (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       LCD_RS,
  input  logic       LCD_E,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_DATA,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [4:0] cursor,
  output logic       char_valid,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       busy,
  output logic       ovr
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [7:0] CH_SPACE = 8'h20;

  // Bus bundle layout: {E, RW, RS, DATA}
  logic [10:0] w_bus;
  logic [10:0] w_stage;
  logic [10:0] r_in;
  logic        r_e_hist;
  logic        w_xact;
  logic        w_rs;
  logic [7:0]  w_d;

  assign w_bus = {LCD_E, LCD_RW, LCD_RS, LCD_DATA};

`ifdef LCD_DEC_SYNC_EN
  logic [10:0] r_meta;
  logic [10:0] r_sync;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= w_bus;
      r_sync <= r_meta;
    end
  end
  assign w_stage = r_sync;
`else
  assign w_stage = w_bus;
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_in     <= '0;
      r_e_hist <= 1'b0;
    end else begin
      r_in     <= w_stage;
      r_e_hist <= r_in[10];
    end
  end

  assign w_xact = r_e_hist & ~r_in[10] & ~r_in[9];
  assign w_rs   = r_in[8];
  assign w_d    = r_in[7:0];

  logic [0:0] r_state;
  logic [4:0] r_clr_idx;
  logic [4:0] r_cursor;
  logic       r_inc;
  logic       r_ovr;
  logic [7:0] r_cmd_code;
  logic       r_char_valid;
  logic       r_cmd_valid;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state      <= ST_IDLE;
      r_clr_idx    <= '0;
      r_cursor     <= '0;
      r_inc        <= 1'b1;
      r_ovr        <= 1'b0;
      r_cmd_code   <= 8'h00;
      r_char_valid <= 1'b0;
      r_cmd_valid  <= 1'b0;
    end else begin
      r_char_valid <= 1'b0;
      r_cmd_valid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_xact && w_rs) begin
            r_char_valid <= 1'b1;
            r_cursor     <= r_inc ? r_cursor + 5'd1 : r_cursor - 5'd1;
          end else if (w_xact) begin
            r_cmd_valid <= 1'b1;
            r_cmd_code  <= w_d;
            if (w_d == 8'h01) begin
              r_cursor  <= '0;
              r_inc     <= 1'b1;
              r_clr_idx <= '0;
              r_state   <= ST_CLEAR;
            end else if (w_d[7:1] == 7'b0000001) begin
              r_cursor <= '0;
            end else if (w_d[7:2] == 6'b000001) begin
              r_inc <= w_d[1];
            end else if (w_d[7]) begin
              // Only 0x00-0x0F (line 1) and 0x40-0x4F (line 2) map onto the shadow
              if (w_d[6:4] == 3'b000)
                r_cursor <= {1'b0, w_d[3:0]};
              else if (w_d[6:4] == 3'b100)
                r_cursor <= {1'b1, w_d[3:0]};
              else
                r_ovr <= 1'b1;
            end
          end
        end
        default: begin
          if (w_xact)
            r_ovr <= 1'b1;
          r_clr_idx <= r_clr_idx + 5'd1;
          if (r_clr_idx == 5'd31)
            r_state <= ST_IDLE;
        end
      endcase
    end
  end

  logic       w_we;
  logic [4:0] w_wr_idx;
  logic [7:0] w_wr_data;

  always_comb begin
    w_we      = 1'b0;
    w_wr_idx  = r_cursor;
    w_wr_data = w_d;
    if (r_state == ST_CLEAR) begin
      w_we      = 1'b1;
      w_wr_idx  = r_clr_idx;
      w_wr_data = CH_SPACE;
    end else if (w_xact && w_rs) begin
      w_we = 1'b1;
    end
  end

  logic [7:0] r_shadow [32];
  logic [7:0] r_rd_data;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < 32; i++)
        r_shadow[i] <= CH_SPACE;
      r_rd_data <= 8'h00;
    end else begin
      if (w_we)
        r_shadow[w_wr_idx] <= w_wr_data;
      r_rd_data <= r_shadow[rd_addr];
    end
  end

  assign rd_data    = r_rd_data;
  assign cursor     = r_cursor;
  assign char_valid = r_char_valid;
  assign cmd_valid  = r_cmd_valid;
  assign cmd_code   = r_cmd_code;
  assign busy       = (r_state == ST_CLEAR);
  assign ovr        = r_ovr;
endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Directed self-checking bench for lcd_bus_decoder; expected latency follows
// LCD_DEC_SYNC_EN (3 cycles) or its absence (1 cycle).
module tb_lcd_bus_decoder;
`ifdef LCD_DEC_SYNC_EN
  localparam int N = 3;
`else
  localparam int N = 1;
`endif

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       LCD_RS = 1'b0;
  logic       LCD_E = 1'b0;
  logic       LCD_RW = 1'b0;
  logic [7:0] LCD_DATA = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic [4:0] cursor;
  logic       char_valid;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic       busy;
  logic       ovr;

  int n_chk = 0;
  int n_pass = 0;
  int busy_cnt;

  lcd_bus_decoder dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .LCD_RS     (LCD_RS),
    .LCD_E      (LCD_E),
    .LCD_RW     (LCD_RW),
    .LCD_DATA   (LCD_DATA),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cursor     (cursor),
    .char_valid (char_valid),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .busy       (busy),
    .ovr        (ovr)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One bus cycle; pulses must be absent N cycles after E falls and present at N+1.
  task automatic bus_xfer(input logic rw, input logic rs, input logic [7:0] d,
                          input logic exp_ch, input logic exp_cmd, input string tag);
    @(negedge iCLK);
    LCD_RW = rw; LCD_RS = rs; LCD_DATA = d; LCD_E = 1'b1;
    repeat (3) @(negedge iCLK);
    LCD_E = 1'b0;
    repeat (N) @(negedge iCLK);
    chk({tag, "_early"}, 32'({char_valid, cmd_valid}), 32'd0);
    @(negedge iCLK);
    chk({tag, "_pulse"}, 32'({char_valid, cmd_valid}), 32'({exp_ch, exp_cmd}));
  endtask

  task automatic read_chk(input logic [4:0] a, input logic [7:0] exp, input string tag);
    @(negedge iCLK);
    rd_addr = a;
    @(negedge iCLK);
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic sweep_spaces(input string tag);
    for (int i = 0; i < 32; i++) read_chk(5'(i), 8'h20, tag);
  endtask

  initial begin
    repeat (3) @(negedge iCLK);
    chk("rst_rd_data", 32'(rd_data), 32'h00);
    chk("rst_cmd_code", 32'(cmd_code), 32'h00);
    iRST = 1'b0;
    @(negedge iCLK);
    chk("rst_cursor", 32'(cursor), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    chk("rst_pulses", 32'({char_valid, cmd_valid}), 32'd0);
    sweep_spaces("rst_sweep");

    bus_xfer(1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "cmd80");
    chk("cmd80_code", 32'(cmd_code), 32'h80);
    bus_xfer(1'b0, 1'b1, 8'h41, 1'b1, 1'b0, "dA");
    bus_xfer(1'b0, 1'b1, 8'h42, 1'b1, 1'b0, "dB");
    chk("ab_cursor", 32'(cursor), 32'd2);
    read_chk(5'd0, 8'h41, "sh0_A");
    read_chk(5'd1, 8'h42, "sh1_B");

    bus_xfer(1'b0, 1'b0, 8'hCF, 1'b0, 1'b1, "cmdCF");
    chk("cf_cursor", 32'(cursor), 32'd31);
    bus_xfer(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, "d5A");
    bus_xfer(1'b0, 1'b1, 8'h5B, 1'b1, 1'b0, "d5B");
    chk("wrap_cursor", 32'(cursor), 32'd1);
    read_chk(5'd31, 8'h5A, "sh31_5A");
    read_chk(5'd0, 8'h5B, "sh0_5B");
    bus_xfer(1'b0, 1'b0, 8'h04, 1'b0, 1'b1, "cmd04");
    bus_xfer(1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "cmd80b");
    bus_xfer(1'b0, 1'b1, 8'h30, 1'b1, 1'b0, "d30");
    chk("dec_wrap_cursor", 32'(cursor), 32'd31);
    read_chk(5'd0, 8'h30, "sh0_30");

    bus_xfer(1'b0, 1'b0, 8'h06, 1'b0, 1'b1, "cmd06");
    bus_xfer(1'b0, 1'b0, 8'h8F, 1'b0, 1'b1, "cmd8F");
    chk("8f_cursor", 32'(cursor), 32'd15);
    bus_xfer(1'b0, 1'b1, 8'h61, 1'b1, 1'b0, "d61");
    chk("line_step_cursor", 32'(cursor), 32'd16);
    read_chk(5'd15, 8'h61, "sh15_61");
    bus_xfer(1'b0, 1'b0, 8'h02, 1'b0, 1'b1, "home");
    chk("home_cursor", 32'(cursor), 32'd0);
    read_chk(5'd15, 8'h61, "home_keeps_sh15");

    for (int i = 0; i < 32; i++)
      bus_xfer(1'b0, 1'b1, 8'h40 + 8'(i), 1'b1, 1'b0, "fill");
    chk("fill_cursor", 32'(cursor), 32'd0);
    read_chk(5'd31, 8'h5F, "fill_sh31");
    read_chk(5'd7, 8'h47, "fill_sh7");
    chk("pre_clear_ovr", 32'(ovr), 32'd0);

    bus_xfer(1'b0, 1'b0, 8'h01, 1'b0, 1'b1, "clear");
    chk("clear_busy_rise", 32'(busy), 32'd1);
    busy_cnt = 1;
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          @(negedge iCLK);
          if (busy) busy_cnt++;
          else break;
        end
      end
      begin
        repeat (9) @(negedge iCLK);
        bus_xfer(1'b0, 1'b1, 8'h99, 1'b0, 1'b0, "drop");
      end
    join
    chk("clear_busy_len", 32'(busy_cnt), 32'd32);
    chk("clear_busy_end", 32'(busy), 32'd0);
    chk("drop_ovr", 32'(ovr), 32'd1);
    chk("clear_cursor", 32'(cursor), 32'd0);
    sweep_spaces("clear_sweep");

    @(negedge iCLK); iRST = 1'b1;
    repeat (2) @(negedge iCLK); iRST = 1'b0;
    chk("rst2_ovr", 32'(ovr), 32'd0);
    bus_xfer(1'b0, 1'b0, 8'h85, 1'b0, 1'b1, "cmd85");
    bus_xfer(1'b0, 1'b0, 8'hA0, 1'b0, 1'b1, "cmdA0");
    chk("a0_ovr", 32'(ovr), 32'd1);
    chk("a0_cursor", 32'(cursor), 32'd5);
    chk("a0_code", 32'(cmd_code), 32'hA0);
    bus_xfer(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, "rw_read");
    chk("rw_cursor", 32'(cursor), 32'd5);
    chk("rw_code", 32'(cmd_code), 32'hA0);
    read_chk(5'd5, 8'h20, "rw_sh5");

    bus_xfer(1'b0, 1'b0, 8'hC8, 1'b0, 1'b1, "cmdC8");
    bus_xfer(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, "d77");
    read_chk(5'd24, 8'h77, "sh24_77");
    bus_xfer(1'b0, 1'b0, 8'h01, 1'b0, 1'b1, "clear2");
    repeat (5) @(negedge iCLK);
    iRST = 1'b1;
    #1;
    chk("midclr_busy", 32'(busy), 32'd0);
    chk("midclr_cursor", 32'(cursor), 32'd0);
    chk("midclr_code", 32'(cmd_code), 32'h00);
    chk("midclr_ovr", 32'(ovr), 32'd0);
    chk("midclr_rd", 32'(rd_data), 32'h00);
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;
    read_chk(5'd24, 8'h20, "midclr_sh24");
    read_chk(5'd31, 8'h20, "midclr_sh31");
    bus_xfer(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, "post_rst");
    chk("post_rst_cursor", 32'(cursor), 32'd1);
    read_chk(5'd0, 8'h55, "post_rst_sh0");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lcd_bus_decoder.md
# lcd_bus_decoder

Passive receiver for the 8-bit HD44780-style LCD bus driven by the CPU's LCD display controller. It samples LCD_RS/LCD_E/LCD_RW/LCD_DATA and decodes each write transaction. It maintains a 32-character shadow of the 16x2 display (DDRAM image plus cursor) and exposes it through a registered read port. The block is used for on-chip readback of displayed PC/OPCODE/DATA and as the self-check end of the LCD path in simulation.

## Interface
- No parameters. Geometry is fixed: 2 lines x 16 characters.
- iCLK, input, 1: system clock (CLOCK_50 domain). Single clock.
- iRST, input, 1: asynchronous reset, active-high.
- LCD_RS, input, 1: register select (0 = command, 1 = data).
- LCD_E, input, 1: bus enable. A transaction latches on the falling edge.
- LCD_RW, input, 1: 0 = write, 1 = read. Read cycles are ignored.
- LCD_DATA, input, 8: bus data.
- rd_addr, input, 5: shadow read index (0-15 = line 1, 16-31 = line 2).
- rd_data, output, 8: shadow[rd_addr], registered.
- cursor, output, 5: current write position.
- char_valid, output, 1: one-cycle pulse on each accepted data write.
- cmd_valid, output, 1: one-cycle pulse on each accepted command.
- cmd_code, output, 8: last accepted command byte.
- busy, output, 1: high while a clear fill is in progress.
- ovr, output, 1: sticky flag. Set when a transaction is dropped while busy, or when a DDRAM address is out of range.

## Operation
- Edge detect: a falling edge of the sampled LCD_E with sampled LCD_RW = 0 forms one transaction. RS and DATA are taken from the same sample as the E falling edge.
- States: IDLE, CLEAR.
- IDLE handles data writes (RS = 1):
  - Write DATA to shadow[cursor] and pulse char_valid.
  - Step cursor by +1 when inc = 1, or -1 when inc = 0.
  - Wrap 31 -> 0 on increment and 0 -> 31 on decrement; 15 -> 16 and 16 -> 15 are ordinary steps.
- IDLE handles commands (RS = 0); every command updates cmd_code and pulses cmd_valid:
  - 0x01 (clear): cursor <= 0, inc <= 1, enter CLEAR.
  - 0x02/0x03 (home): cursor <= 0. Shadow is unchanged.
  - 0000_01xx (entry mode): inc <= bit 1.
  - 1aaa_aaaa (set DDRAM): address 0x00-0x0F gives cursor = a; 0x40-0x4F gives cursor = 16 + a[3:0]. Any other address sets ovr and leaves cursor unchanged.
  - All other commands (function set, display control, shift): only cmd_code/cmd_valid change.
- CLEAR state:
  - Writes 0x20 into one entry per cycle, index 0 through 31, for 32 cycles. busy = 1 throughout, then the block returns to IDLE.
  - A transaction arriving during CLEAR is dropped and sets ovr. A dropped transaction produces no pulses.
- Read port: rd_data <= shadow[rd_addr] every cycle. When the read and a write hit the same index in the same cycle, rd_data returns the old value.
- Reset (any time, including mid-CLEAR):
  - All shadow entries = 0x20, cursor = 0, inc = 1, state = IDLE.
  - busy = 0, ovr = 0, char_valid = 0, cmd_valid = 0, cmd_code = 0x00, rd_data = 0x00.
  - Edge-detect history resets to E = 0, so no spurious edge is detected after reset.

## Timing
- char_valid, cmd_valid, cursor and shadow updates all take effect on the same iCLK edge, N cycles after the first iCLK edge that samples the pin LCD_E low. N = 3 with LCD_DEC_SYNC_EN and N = 1 without it.
- busy rises on the cycle cmd_valid pulses for 0x01 and stays high for exactly 32 cycles.
- rd_data latency is 1 cycle from rd_addr.
- LCD_E must stay high for at least 2 iCLK cycles and low for at least 2 iCLK cycles. Shorter pulses are not guaranteed to be seen.
- At most one transaction is processed per E falling edge. There are no back-to-back conflicts because E pulses are at least 4 cycles apart.

## Configuration
- LCD_DEC_SYNC_EN
  - Defined: every bus input passes through a 2-flop synchronizer, followed by one edge-history register. Use this when the bus is driven from another clock or from pins.
  - Undefined: each input is registered once, and that register doubles as edge history; inputs must be synchronous to iCLK. Latency N drops from 3 to 1. Functional behaviour is otherwise identical.

## Test plan
- Reset, then sweep rd_addr 0-31 -> every rd_data = 0x20; cursor = 0, busy = 0, ovr = 0.
- Send command 0x80, then data 0x41, 0x42 -> shadow[0] = 0x41, shadow[1] = 0x42, cursor = 2, two char_valid pulses, N cycles after each E fall.
- Send 0xCF, then data 0x5A, 0x5B -> shadow[31] = 0x5A, shadow[0] = 0x5B, cursor = 1. Send 0x04, 0x80, data 0x30 -> shadow[0] = 0x30, cursor = 31.
- Fill the display, send 0x01, then a data write 10 cycles later -> busy high 32 cycles, all entries 0x20, dropped write leaves shadow unchanged, ovr = 1.
- Send 0xA0 -> ovr = 1, cursor unchanged, cmd_code = 0xA0. Send an RW = 1 cycle with E toggling -> no pulses, no state change.
- Assert iRST 5 cycles into a clear -> busy = 0 immediately; after release all entries = 0x20 and state = IDLE. Run once with LCD_DEC_SYNC_EN defined and once undefined, checking N = 3 and N = 1 respectively.
